// File: rtl/spi_pkg.sv
// Shared types and constants for the 16-bit SPI responder.
package spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE,
    FRONT,
    SHIFT
  } spi_slv_state_t;
endpackage

// File: rtl/spi_slv16_if.sv
// Host-side handshake between the SPI responder and the logic that feeds it.
interface spi_slv16_if;
  import spi_pkg::*;

  logic                  wrt;
  logic [FRAME_BITS-1:0] tx_data;
  logic                  clr_rdy;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rdy;
  logic                  err;

  modport master (output wrt, tx_data, clr_rdy, input rx_data, rdy, err);
  modport slave  (input wrt, tx_data, clr_rdy, output rx_data, rdy, err);
endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer plus a history flop for edge detection on an async pin.
module spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic meta;
  logic hist;

  // rst_val lets idle-high pins come out of reset without a phantom edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= rst_val;
      sync <= rst_val;
      hist <= rst_val;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;
  assign fall = ~sync & hist;
endmodule

// File: rtl/spi_slv16.sv
// 16-bit SPI responder: SCLK idle high, MSB first, sample on rise, shift on fall.
module spi_slv16
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output wire         MISO,
  spi_slv16_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_slv_state_t        state;
  logic [FRAME_BITS-1:0] tx_buf;
  logic [FRAME_BITS-1:0] tx_shft;
  logic [FRAME_BITS-1:0] rx_shft;
  logic [FRAME_BITS-1:0] rx_data;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  rdy;
  logic                  err;

  spi_sync u_ss_sync (
    .clk(clk), .rst_n(rst_n), .rst_val(1'b1), .din(SS_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .rst_val(1'b1), .din(SCLK),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .rst_val(1'b0), .din(MOSI),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf <= '0;
    end else if (bus.wrt) begin
      tx_buf <= bus.tx_data;
    end
  end

  // Frame FSM; rdy set at frame end is placed after clr_rdy so set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_shft <= '0;
      rx_shft <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      rdy     <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (bus.clr_rdy) rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= FRONT;
            tx_shft <= bus.wrt ? bus.tx_data : tx_buf;
            bit_cnt <= '0;
            rdy     <= 1'b0;
          end
        end
        FRONT, SHIFT: begin
          if (ss_rise) begin
            state <= IDLE;
            if (bit_cnt == CNT_FULL) begin
              rx_data <= rx_shft;
              rdy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_shft <= {rx_shft[FRAME_BITS-2:0], mosi_sync};
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
              if (state == FRONT) state <= SHIFT;
            end
            // The master's leading fall lands in FRONT and must not shift
            if (sclk_fall && state == SHIFT) begin
              tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO        = SS_n ? 1'bz : tx_shft[FRAME_BITS-1];
  assign bus.rx_data = rx_data;
  assign bus.rdy     = rdy;
  assign bus.err     = err;
endmodule

// File: tb/tb_spi_slv16.sv
// Self-checking bench for spi_slv16: a bit-banged SPI master plus a word-level model.
module tb_spi_slv16;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ss_n;
  logic sclk;
  logic mosi;
  wire  miso;

  spi_slv16_if bus ();

  spi_slv16 dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk),
    .MOSI(mosi), .MISO(miso), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_tx_buf;
  logic [15:0] model_rx;
  logic        model_rdy;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish within bound");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic writeTx(input logic [15:0] w);
    bus.tx_data = w;
    bus.wrt     = 1'b1;
    tick();
    bus.wrt     = 1'b0;
    model_tx_buf = w;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rdy"}, 32'(bus.rdy), 32'(1'b0));
    checkOutput({tag, "_err"}, 32'(bus.err), 32'(1'b0));
    checkOutput({tag, "_rx"}, 32'(bus.rx_data), 32'h0);
  endtask

  // One master frame of n rises; optional mid-frame wrt, clr_rdy on the set cycle, or reset after rst_at rises
  task automatic applyStimulus(input logic [15:0] word, input int n, input int wrt_at,
                               input logic [15:0] wrt_word, input bit clr_at_set,
                               input int rst_at, output logic [15:0] rd);
    logic [15:0] sent_tx;
    bit          err_exp;
    int          idx;
    sent_tx   = model_tx_buf;
    rd        = '0;
    ss_n      = 1'b0;
    model_rdy = 1'b0;
    tick(4);
    checkOutput("rdy_clr_at_fall", 32'(bus.rdy), 32'(1'b0));
    tick(26);
    if (n > 0) begin
      sclk = 1'b0;
      mosi = word[15];
      tick(8);
    end
    for (int i = 0; i < n; i++) begin
      rd   = {rd[14:0], miso};
      sclk = 1'b1;
      if (i == wrt_at) begin
        bus.tx_data  = wrt_word;
        bus.wrt      = 1'b1;
        tick();
        bus.wrt      = 1'b0;
        model_tx_buf = wrt_word;
        tick(7);
      end else begin
        tick(8);
      end
      if (i + 1 == rst_at) begin
        rst_n = 1'b0;
        ss_n  = 1'b1;
        sclk  = 1'b1;
        mosi  = 1'b0;
        tick(3);
        checkResetValues("mid_reset");
        rst_n        = 1'b1;
        model_tx_buf = '0;
        model_rx     = '0;
        model_rdy    = 1'b0;
        tick(4);
        return;
      end
      if (i < n - 1) begin
        idx  = 14 - i;
        sclk = 1'b0;
        mosi = (idx >= 0) ? word[idx] : 1'b0;
        tick(8);
      end
    end
    ss_n = 1'b1;
    tick(2);
    checkOutput("err_early", 32'(bus.err), 32'(1'b0));
    checkOutput("rdy_early", 32'(bus.rdy), 32'(1'b0));
    if (clr_at_set) bus.clr_rdy = 1'b1;
    tick();
    bus.clr_rdy = 1'b0;
    err_exp = (n != FRAME_BITS);
    if (!err_exp) begin
      model_rx  = word;
      model_rdy = 1'b1;
    end
    checkOutput("err_end", 32'(bus.err), 32'(err_exp));
    checkOutput("rdy_end", 32'(bus.rdy), 32'(model_rdy));
    checkOutput("rx_data", 32'(bus.rx_data), 32'(model_rx));
    tick();
    checkOutput("err_one_cycle", 32'(bus.err), 32'(1'b0));
    if (!err_exp) checkOutput("rd_data", 32'(rd), 32'(sent_tx));
    tick(4);
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] w;
    int          n;
    int          wat;
    rst_n        = 1'b0;
    ss_n         = 1'b1;
    sclk         = 1'b1;
    mosi         = 1'b0;
    bus.wrt      = 1'b0;
    bus.tx_data  = '0;
    bus.clr_rdy  = 1'b0;
    model_tx_buf = '0;
    model_rx     = '0;
    model_rdy    = 1'b0;
    tick(3);
    checkResetValues("in_reset");
    rst_n = 1'b1;
    tick(4);
    checkResetValues("after_reset");

    writeTx(16'hA5C3);
    applyStimulus(16'h1234, 16, -1, 16'h0, 1'b0, -1, rd);

    writeTx(16'h0F0F);
    applyStimulus(16'($urandom), 16, 5, 16'hFFFF, 1'b0, -1, rd);
    applyStimulus(16'($urandom), 16, -1, 16'h0, 1'b0, -1, rd);

    applyStimulus(16'($urandom), 7, -1, 16'h0, 1'b0, -1, rd);
    applyStimulus(16'hBEEF, 16, -1, 16'h0, 1'b0, -1, rd);

    applyStimulus(16'($urandom), 16, -1, 16'h0, 1'b1, -1, rd);
    bus.clr_rdy = 1'b1;
    tick();
    bus.clr_rdy = 1'b0;
    model_rdy   = 1'b0;
    checkOutput("rdy_after_clr", 32'(bus.rdy), 32'(model_rdy));

    applyStimulus(16'($urandom), 48, -1, 16'h0, 1'b0, -1, rd);

    applyStimulus(16'($urandom), 16, -1, 16'h0, 1'b0, 9, rd);
    applyStimulus(16'h8001, 16, -1, 16'h0, 1'b0, -1, rd);

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) writeTx(16'($urandom));
      n   = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 20));
      wat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1;
      w   = 16'($urandom);
      applyStimulus(w, n, wat, 16'($urandom), 1'($urandom_range(0, 1)), -1, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
